// File: rtl/mem_access_ctrl_pkg.sv
// Shared op and FSM encodings for the load/store access controller.
// Decode helpers keep the alignment rules in one place.
package mem_access_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   function automatic logic op_is_load(op_e op);
      return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
             (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic op_misaligned(op_e op, logic [1:0] lo);
      logic word_op, half_op;
      word_op = (op == OP_LW) || (op == OP_SW);
      half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      return (word_op && (lo != 2'b00)) || (half_op && lo[0]);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with sign/zero extension for loads, and
// read-modify-write lane merge for sub-word stores. Purely combinational.
module lsu_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  op_e         op,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b          = word[{lane, 3'b000} +: 8];
      h          = lane[1] ? word[31:16] : word[15:0];
      load_data  = word;
      merge_data = word;
      case (op)
         OP_LH:  load_data = {{16{h[15]}}, h};
         OP_LHU: load_data = {16'h0000, h};
         OP_LB:  load_data = {{24{b[7]}}, b};
         OP_LBU: load_data = {24'h000000, b};
         OP_SW:  merge_data = wdata;
         OP_SH: begin
            if (lane[1]) merge_data[31:16] = wdata[15:0];
            else         merge_data[15:0]  = wdata[15:0];
         end
         OP_SB:  merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU load/store controller: IDLE -> READ/WRITE -> RESP.
// Sub-word stores do a read-modify-write through lsu_lane_align.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_pc,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   state_e      state;
   op_e         op_q;
   logic [31:0] addr_q, wdata_q, pc_q, rdata_q, merged_q;
   logic        err_q;
   logic [31:0] load_data, merge_data;
   op_e         req_op_e;
   logic        req_bad;

   assign req_op_e = op_e'(req_op);
   assign req_bad  = op_misaligned(req_op_e, req_addr[1:0]) ||
                     ((req_addr >> ADDR_BITS) != 32'd0);

   lsu_lane_align u_align (
      .op         (op_q),
      .lane       (addr_q[1:0]),
      .word       (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         op_q     <= OP_LW;
         addr_q   <= '0;
         wdata_q  <= '0;
         pc_q     <= '0;
         rdata_q  <= '0;
         merged_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               op_q     <= req_op_e;
               addr_q   <= req_addr;
               wdata_q  <= req_wdata;
               pc_q     <= req_pc;
               rdata_q  <= '0;
               merged_q <= '0;
               err_q    <= req_bad;
               if (req_bad)                 state <= ST_RESP;
               else if (req_op_e == OP_SW)  state <= ST_WRITE;
               else                         state <= ST_READ;
            end
            ST_READ: begin
               // Loads keep the extended lane; SH/SB keep the merged word.
               rdata_q  <= op_is_load(op_q) ? load_data : '0;
               merged_q <= merge_data;
               state    <= op_is_load(op_q) ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: state <= ST_RESP;
            ST_RESP:  if (resp_ready) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   logic in_mem, in_write;
   assign in_mem   = (state == ST_READ) || (state == ST_WRITE);
   assign in_write = (state == ST_WRITE);

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_err   = resp_valid & err_q;

   // Reset during WRITE must kill the strobe in that same cycle.
   assign mem_we    = in_write & ~reset;
   assign mem_addr  = in_mem ? {addr_q[31:2], 2'b00} : '0;
   assign mem_wdata = in_write ? ((op_q == OP_SW) ? wdata_q : merged_q) : '0;
   assign mem_pc    = in_write ? pc_q : '0;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_BITS, default 12, giving the byte-address width of the word memory; the word index is addr[ADDR_BITS-1:2].
REQ-002 The module SHALL have port clk, input, 1 bit, the clock; reset is reset, synchronous, active-high, and the clock is clk.
REQ-003 The module SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-004 The module SHALL have port req_valid, input, 1 bit, the CPU access request.
REQ-005 The module SHALL have port req_ready, output, 1 bit, asserted when the controller accepts a request.
REQ-006 The module SHALL have port req_op, input, 3 bits: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-007 The module SHALL have ports req_addr, req_wdata and req_pc, inputs, 32 bits each: the byte address, the store data (right-aligned), and the instruction PC.
REQ-008 The module SHALL have port resp_valid, output, 1 bit, and port resp_ready, input, 1 bit, forming the response handshake.
REQ-009 The module SHALL have ports resp_rdata, output, 32 bits (extended load data), and resp_err, output, 1 bit (misaligned or out-of-range).
REQ-010 The module SHALL have ports mem_addr, mem_wdata and mem_pc, outputs, 32 bits each; mem_we, output, 1 bit; and mem_rdata, input, 32 bits, read combinationally at mem_addr in the same cycle.

Function
REQ-011 The FSM SHALL have states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 In IDLE, when req_valid=1, the module SHALL latch op, addr, wdata and pc.
REQ-013 After the latch in REQ-012, the FSM SHALL move to RESP with err=1 when the request is misaligned or out of range.
REQ-014 A request SHALL be misaligned for word ops with addr[1:0]!=0 and for half ops with addr[0]!=0.
REQ-015 A request SHALL be out of range when addr[31:ADDR_BITS]!=0.
REQ-016 For a valid request, the FSM SHALL move from IDLE to READ for loads, SH and SB, and from IDLE to WRITE for SW.
REQ-017 In READ, mem_addr SHALL be {addr[31:2],2'b00} and mem_we=0, and mem_rdata SHALL be captured at the clock edge.
REQ-018 From READ, loads SHALL go to RESP and SH/SB SHALL go to WRITE.
REQ-019 LH/LB SHALL sign-extend the selected lane and LHU/LBU SHALL zero-extend it; lanes are little-endian, byte k = bits 8k+7:8k.
REQ-020 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr equal to the aligned address.
REQ-021 In WRITE, mem_wdata SHALL be req_wdata for SW, and for SH/SB SHALL be the captured word with only the addressed lane(s) replaced by the low bits of req_wdata.
REQ-022 In WRITE, mem_pc SHALL equal the latched pc; mem_pc SHALL be 0 outside WRITE.
REQ-023 After WRITE, the FSM SHALL go to RESP.
REQ-024 In RESP, resp_valid=1 SHALL hold, with resp_rdata and resp_err stable, until resp_ready=1; the FSM SHALL then return to IDLE on the same edge.
REQ-025 resp_rdata SHALL be 0 for stores and for errored requests.
REQ-026 Latency from the accept edge to resp_valid SHALL be: LW/LH/LHU/LB/LBU 2 cycles, SW 2 cycles, SH/SB 3 cycles, error 1 cycle.
REQ-027 Back-to-back requests SHALL NOT be accepted while not in IDLE; there SHALL be no request overlap.
REQ-028 Outside READ/WRITE, mem_addr, mem_wdata and mem_we SHALL all be 0.
REQ-029 An errored request SHALL never assert mem_we.

Reset
REQ-030 When reset=1 at a rising edge, the state SHALL become IDLE and all latched registers SHALL be cleared to 0.
REQ-031 mem_we SHALL be gated by !reset, so a reset asserted during WRITE suppresses that write.
REQ-032 After reset, outputs SHALL be req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, and all mem_* outputs 0.
REQ-033 A request pending during reset SHALL be dropped with no response.

Structure
REQ-034 The op encodings and FSM state encodings SHALL live in a shared package used by the decode logic and the testbench.
REQ-035 Byte-lane extraction, extension and merge SHALL be a combinational sub-module named lsu_lane_align.

Verification
REQ-036 The bench SHALL cover: memory word 0x100 = 0x8899AABB; LB addr 0x101 -> resp_rdata 0xFFFFFFAA at 2 cycles; LBU addr 0x101 -> 0x000000AA.
REQ-037 The bench SHALL cover: SB addr 0x102, wdata 0x12 on word 0x8899AABB -> READ, then one write of 0x8812AABB to 0x100 at cycle 2, resp_valid at cycle 3, resp_err=0.
REQ-038 The bench SHALL cover: LW addr 0x0103 -> resp_err=1 at 1 cycle, mem_we never asserted, no memory access.
REQ-039 The bench SHALL cover: SW addr 0x2000 with ADDR_BITS=12 -> resp_err=1 and memory unchanged.
REQ-040 The bench SHALL cover: resp_ready held 0 for 3 cycles after LH addr 0x102 -> resp_valid and resp_rdata 0xFFFF8899 stable, req_ready=0 throughout.
REQ-041 The bench SHALL cover: reset asserted during the WRITE cycle of SH -> mem_we=0 on that edge, FSM in IDLE, and no response.
